// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and result channels between the control side,
// the sequencer and the combinational ALU.
interface alu_op_sequencer_if #(
    parameter int N    = 4,
    parameter int OP_W = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [OP_W-1:0] cmd_op;
    logic [N-1:0]    cmd_a;
    logic [N-1:0]    cmd_b;
    logic [OP_W-1:0] alu_op;
    logic [N-1:0]    alu_a;
    logic [N-1:0]    alu_b;
    logic [N-1:0]    alu_result;
    logic [3:0]      alu_flags;
    logic            res_valid;
    logic            res_ready;
    logic [N-1:0]    res_data;
    logic [3:0]      res_flags;
    logic            res_err;

    // Control side plus ALU model: issues commands, consumes results.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_result, alu_flags, res_ready,
        input  cmd_ready, alu_op, alu_a, alu_b,
        input  res_valid, res_data, res_flags, res_err
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_result, alu_flags, res_ready,
        output cmd_ready, alu_op, alu_a, alu_b,
        output res_valid, res_data, res_flags, res_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command per handshake: registers operands,
// captures result/flags, returns them with sticky status and a count.
module alu_op_sequencer #(
    parameter int N       = 4,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 10,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.slave bus,
    input  logic             clr_sticky,
    output logic [3:0]       sticky_flags,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [OP_W:0] NUM_OPS_W = (OP_W+1)'(NUM_OPS);

    state_t state;
    logic   legal;
    logic   hs;

    assign legal = ({1'b0, bus.alu_op} < NUM_OPS_W);
    assign hs    = (state == DONE) && bus.res_ready;

    // Accept in IDLE, or in DONE when the current result is taken.
    always_comb begin
        bus.cmd_ready = 1'b0;
        unique case (state)
            IDLE:    bus.cmd_ready = 1'b1;
            DONE:    bus.cmd_ready = bus.res_ready;
            default: bus.cmd_ready = 1'b0;
        endcase
    end

    // Sequencer FSM with registered ALU operands, result and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.alu_op    <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_flags <= '0;
            bus.res_err   <= 1'b0;
            sticky_flags  <= '0;
            ops_done      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.alu_op <= bus.cmd_op;
                        bus.alu_a  <= bus.cmd_a;
                        bus.alu_b  <= bus.cmd_b;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (legal) begin
                        bus.res_data  <= bus.alu_result;
                        bus.res_flags <= bus.alu_flags;
                        bus.res_err   <= 1'b0;
                    end else begin
                        bus.res_data  <= '0;
                        bus.res_flags <= '0;
                        bus.res_err   <= 1'b1;
                    end
                    bus.res_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (hs) begin
                        ops_done      <= ops_done + CNT_W'(1);
                        sticky_flags  <= sticky_flags | bus.res_flags;
                        bus.res_valid <= 1'b0;
                        if (bus.cmd_valid) begin
                            bus.alu_op <= bus.cmd_op;
                            bus.alu_a  <= bus.cmd_a;
                            bus.alu_b  <= bus.cmd_b;
                            state      <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (clr_sticky) begin
                sticky_flags <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small ALU model
// (op0 ADD, op3 NOT, anything else passes A through).
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_sticky;
    logic [3:0] sticky_flags;
    logic [7:0] ops_done;
    int         checks = 0;
    int         errors = 0;

    alu_op_sequencer_if #(.N(4), .OP_W(4)) bus ();

    alu_op_sequencer #(
        .N(4), .OP_W(4), .NUM_OPS(10), .CNT_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .clr_sticky   (clr_sticky),
        .sticky_flags (sticky_flags),
        .ops_done     (ops_done)
    );

    always #5 clk = ~clk;

    // Reference ALU, flags {N,Z,C,V}.
    logic [4:0] sum;
    always_comb begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = bus.alu_a;
        bus.alu_flags  = '0;
        case (bus.alu_op)
            4'd0: begin
                bus.alu_result   = sum[3:0];
                bus.alu_flags[1] = sum[4];
                bus.alu_flags[0] = (bus.alu_a[3] == bus.alu_b[3])
                                 && (sum[3] != bus.alu_a[3]);
            end
            4'd3: bus.alu_result = ~bus.alu_a;
            default: bus.alu_result = bus.alu_a;
        endcase
        bus.alu_flags[3] = bus.alu_result[3];
        bus.alu_flags[2] = (bus.alu_result == 4'h0);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge (accepted from IDLE), then drop it.
    task automatic send(input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Take the pending result, optionally clearing sticky flags the same cycle.
    task automatic take(input logic clr);
        bus.res_ready = 1'b1;
        clr_sticky    = clr;
        step();
        bus.res_ready = 1'b0;
        clr_sticky    = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_sticky    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_alu_op", 32'(bus.alu_op), 0);
        chk("rst_alu_a", 32'(bus.alu_a), 0);
        chk("rst_alu_b", 32'(bus.alu_b), 0);
        chk("rst_res_data", 32'(bus.res_data), 0);
        chk("rst_res_flags", 32'(bus.res_flags), 0);
        chk("rst_res_err", 32'(bus.res_err), 0);
        chk("rst_sticky", 32'(sticky_flags), 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        rst_n = 1'b1;
        step();

        // NOT 4'hF -> 0, Z set
        send(4'd3, 4'hF, 4'h0);
        chk("exec_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("exec_res_valid", 32'(bus.res_valid), 0);
        chk("exec_alu_op", 32'(bus.alu_op), 3);
        chk("exec_alu_a", 32'(bus.alu_a), 32'hF);
        step();
        chk("not_f_valid", 32'(bus.res_valid), 1);
        chk("not_f_data", 32'(bus.res_data), 0);
        chk("not_f_flags", 32'(bus.res_flags), 32'b0100);
        chk("not_f_err", 32'(bus.res_err), 0);
        take(1'b0);
        chk("not_f_ops", 32'(ops_done), 1);
        chk("not_f_sticky", 32'(sticky_flags), 32'b0100);
        chk("not_f_idle_valid", 32'(bus.res_valid), 0);
        chk("not_f_idle_ready", 32'(bus.cmd_ready), 1);

        // NOT 4'h5 -> 4'hA, N set
        send(4'd3, 4'h5, 4'h0);
        step();
        chk("not_5_data", 32'(bus.res_data), 32'hA);
        chk("not_5_flags", 32'(bus.res_flags), 32'b1000);
        take(1'b0);
        chk("not_5_ops", 32'(ops_done), 2);
        chk("not_5_sticky", 32'(sticky_flags), 32'b1100);

        // Reset while in EXEC discards the command
        send(4'd3, 4'h5, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("rstx_res_valid", 32'(bus.res_valid), 0);
        chk("rstx_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rstx_alu_a", 32'(bus.alu_a), 0);
        chk("rstx_ops", 32'(ops_done), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstx_no_valid", 32'(bus.res_valid), 0);
        end

        // Back-to-back: ADD 3+4, NOT 0, ADD F+1
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 4'd0; bus.cmd_a = 4'h3; bus.cmd_b = 4'h4;
        step();
        chk("b2b_exec0_valid", 32'(bus.res_valid), 0);
        bus.cmd_op = 4'd3; bus.cmd_a = 4'h0; bus.cmd_b = 4'h0;
        step();
        chk("b2b_r0_valid", 32'(bus.res_valid), 1);
        chk("b2b_r0_data", 32'(bus.res_data), 7);
        chk("b2b_r0_flags", 32'(bus.res_flags), 0);
        chk("b2b_r0_ready", 32'(bus.cmd_ready), 1);
        step();
        chk("b2b_exec1_valid", 32'(bus.res_valid), 0);
        chk("b2b_exec1_ops", 32'(ops_done), 1);
        bus.cmd_op = 4'd0; bus.cmd_a = 4'hF; bus.cmd_b = 4'h1;
        step();
        chk("b2b_r1_valid", 32'(bus.res_valid), 1);
        chk("b2b_r1_data", 32'(bus.res_data), 32'hF);
        chk("b2b_r1_flags", 32'(bus.res_flags), 32'b1000);
        step();
        bus.cmd_valid = 1'b0;
        chk("b2b_exec2_valid", 32'(bus.res_valid), 0);
        step();
        chk("b2b_r2_valid", 32'(bus.res_valid), 1);
        chk("b2b_r2_data", 32'(bus.res_data), 0);
        chk("b2b_r2_flags", 32'(bus.res_flags), 32'b0110);
        step();
        bus.res_ready = 1'b0;
        chk("b2b_ops", 32'(ops_done), 3);
        chk("b2b_sticky", 32'(sticky_flags), 32'b1110);
        chk("b2b_end_valid", 32'(bus.res_valid), 0);

        // Backpressure with a waiting command that must be ignored
        send(4'd0, 4'h2, 4'h3);
        step();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 4'd0; bus.cmd_a = 4'h9; bus.cmd_b = 4'h9;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(bus.res_valid), 1);
            chk("bp_data", 32'(bus.res_data), 5);
            chk("bp_flags", 32'(bus.res_flags), 0);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("bp_alu_a", 32'(bus.alu_a), 2);
        end

        // Release with an illegal opcode queued
        bus.cmd_op = 4'd12;
        bus.res_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        chk("ill_ops", 32'(ops_done), 4);
        chk("ill_alu_op", 32'(bus.alu_op), 12);
        chk("ill_alu_a", 32'(bus.alu_a), 9);
        step();
        chk("ill_valid", 32'(bus.res_valid), 1);
        chk("ill_err", 32'(bus.res_err), 1);
        chk("ill_data", 32'(bus.res_data), 0);
        chk("ill_flags", 32'(bus.res_flags), 0);
        take(1'b0);
        chk("ill_ops_after", 32'(ops_done), 5);
        chk("ill_sticky", 32'(sticky_flags), 32'b1110);
        send(4'd3, 4'h6, 4'h0);
        step();
        chk("legal_err", 32'(bus.res_err), 0);
        chk("legal_data", 32'(bus.res_data), 9);
        chk("legal_flags", 32'(bus.res_flags), 32'b1000);
        take(1'b0);
        chk("legal_ops", 32'(ops_done), 6);

        // Counter up to 8'hFF, then wrap with sticky clear
        for (int i = 0; i < 249; i++) begin
            send(4'd0, 4'h0, 4'h0);
            step();
            take(1'b0);
        end
        chk("cnt_ff", 32'(ops_done), 32'hFF);
        chk("cnt_sticky", 32'(sticky_flags), 32'b1110);
        send(4'd0, 4'h0, 4'h0);
        step();
        chk("wrap_flags", 32'(bus.res_flags), 32'b0100);
        take(1'b1);
        chk("wrap_ops", 32'(ops_done), 0);
        chk("wrap_sticky", 32'(sticky_flags), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
